// File: rtl/npc_bp_pkg.sv
// Shared configuration, counter constants and BTB entry layout for the npc_bp next-PC unit.
// Optional statistics counters are enabled with the NPC_BP_STATS_EN macro.
package npc_bp_pkg;

  localparam int ADDR_W    = 32;
  localparam int BTB_DEPTH = 16;
  localparam int CTR_W     = 2;
  localparam int IDX_W     = $clog2(BTB_DEPTH);
  localparam int TAG_W     = ADDR_W - IDX_W - 2;

  localparam logic [ADDR_W-1:0] RESET_PC   = 32'h0000_3000;
  localparam logic [CTR_W-1:0]  CTR_MAX    = '1;
  localparam logic [CTR_W-1:0]  CTR_WEAK_T = CTR_W'(1) << (CTR_W - 1);

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [ADDR_W-1:0] tgt;
    logic [CTR_W-1:0]  ctr;
    logic              uncond;
  } btb_entry_t;

  function automatic logic [CTR_W-1:0] ctr_inc(input logic [CTR_W-1:0] c);
    return (c == CTR_MAX) ? c : c + CTR_W'(1);
  endfunction

  function automatic logic [CTR_W-1:0] ctr_dec(input logic [CTR_W-1:0] c);
    return (c == '0) ? c : c - CTR_W'(1);
  endfunction

endpackage

// File: rtl/npc_bp_if.sv
// Fetch-side and resolve-side signals of the npc_bp next-PC unit.
// NPC_BP_STATS_EN adds the stat_resolved / stat_mispred counter outputs.
interface npc_bp_if;
  import npc_bp_pkg::*;

  // res_valid qualifies res_* for exactly one cycle; there is no ready, the unit
  // always accepts a resolve, and res_* are ignored while res_valid is low.
  logic              stall;
  logic [ADDR_W-1:0] pc;
  logic              pred_taken;
  logic [ADDR_W-1:0] pred_target;
  logic              res_valid;
  logic [ADDR_W-1:0] res_pc;
  logic              res_uncond;
  logic              res_taken;
  logic [ADDR_W-1:0] res_target;
  logic              res_pred_taken;
  logic [ADDR_W-1:0] res_pred_target;
  logic              flush;
`ifdef NPC_BP_STATS_EN
  logic [31:0]       stat_resolved;
  logic [31:0]       stat_mispred;

  modport master (
    output stall, res_valid, res_pc, res_uncond, res_taken, res_target,
           res_pred_taken, res_pred_target,
    input  pc, pred_taken, pred_target, flush, stat_resolved, stat_mispred
  );
  modport slave (
    input  stall, res_valid, res_pc, res_uncond, res_taken, res_target,
           res_pred_taken, res_pred_target,
    output pc, pred_taken, pred_target, flush, stat_resolved, stat_mispred
  );
`else
  modport master (
    output stall, res_valid, res_pc, res_uncond, res_taken, res_target,
           res_pred_taken, res_pred_target,
    input  pc, pred_taken, pred_target, flush
  );
  modport slave (
    input  stall, res_valid, res_pc, res_uncond, res_taken, res_target,
           res_pred_taken, res_pred_target,
    output pc, pred_taken, pred_target, flush
  );
`endif

endinterface

// File: rtl/npc_bp_btb.sv
// Direct-mapped branch target buffer: flop array, two async read ports, one sync write port.
// Reset clears only the valid bits; the payload fields are don't-care while invalid.
module npc_bp_btb
  import npc_bp_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx_a,
  output btb_entry_t       rd_entry_a,
  input  logic [IDX_W-1:0] rd_idx_b,
  output btb_entry_t       rd_entry_b,
  input  logic             we,
  input  logic [IDX_W-1:0] wr_idx,
  input  btb_entry_t       wr_entry
);

  btb_entry_t mem [BTB_DEPTH];

  assign rd_entry_a = mem[rd_idx_a];
  assign rd_entry_b = mem[rd_idx_b];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BTB_DEPTH; i++) mem[i].valid <= 1'b0;
    end else if (we) begin
      mem[wr_idx] <= wr_entry;
    end
  end

endmodule

// File: rtl/npc_bp.sv
// Next-PC unit: fetch PC register, BTB-based prediction and mispredict repair.
// Defining NPC_BP_STATS_EN adds resolved/mispredict event counters.
module npc_bp
  import npc_bp_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  npc_bp_if.slave  bus
);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;
  logic [IDX_W-1:0]  fetch_idx;
  logic [TAG_W-1:0]  fetch_tag;
  logic [IDX_W-1:0]  res_idx;
  logic [TAG_W-1:0]  res_tag;
  btb_entry_t        fetch_e;
  btb_entry_t        res_e;
  btb_entry_t        wr_e;
  logic              fetch_hit;
  logic              res_hit;
  logic              pred_taken_c;
  logic [ADDR_W-1:0] pred_target_c;
  logic              mis;
  logic              we;

  assign fetch_idx = pc_q[IDX_W+1:2];
  assign fetch_tag = pc_q[ADDR_W-1:IDX_W+2];
  assign res_idx   = bus.res_pc[IDX_W+1:2];
  assign res_tag   = bus.res_pc[ADDR_W-1:IDX_W+2];

  npc_bp_btb u_btb (
    .clk        (clk),
    .rst        (rst),
    .rd_idx_a   (fetch_idx),
    .rd_entry_a (fetch_e),
    .rd_idx_b   (res_idx),
    .rd_entry_b (res_e),
    .we         (we),
    .wr_idx     (res_idx),
    .wr_entry   (wr_e)
  );

  assign fetch_hit     = fetch_e.valid && (fetch_e.tag == fetch_tag);
  assign res_hit       = res_e.valid && (res_e.tag == res_tag);
  assign pred_taken_c  = fetch_hit && (fetch_e.uncond || fetch_e.ctr[CTR_W-1]);
  assign pred_target_c = fetch_hit ? fetch_e.tgt : '0;

  // A correct not-taken prediction ignores the target; a taken one must match it.
  assign mis = bus.res_valid &&
               ((bus.res_taken != bus.res_pred_taken) ||
                (bus.res_taken && (bus.res_target != bus.res_pred_target)));

  assign bus.pc          = pc_q;
  assign bus.pred_taken  = pred_taken_c && !rst;
  assign bus.pred_target = rst ? '0 : pred_target_c;
  assign bus.flush       = mis && !rst;

  always_comb begin
    pc_d = pc_q + ADDR_W'(4);
    if (mis)                pc_d = bus.res_taken ? bus.res_target : bus.res_pc + ADDR_W'(4);
    else if (bus.stall)     pc_d = pc_q;
    else if (pred_taken_c)  pc_d = pred_target_c;
  end

  always_ff @(posedge clk) begin
    if (rst) pc_q <= RESET_PC;
    else     pc_q <= pc_d;
  end

  // Not-taken resolves never allocate; they only weaken an existing entry.
  always_comb begin
    we   = 1'b0;
    wr_e = res_e;
    if (bus.res_valid) begin
      if (bus.res_taken) begin
        we = 1'b1;
        if (res_hit) begin
          wr_e.tgt = bus.res_target;
          wr_e.ctr = ctr_inc(res_e.ctr);
        end else begin
          wr_e.valid  = 1'b1;
          wr_e.tag    = res_tag;
          wr_e.tgt    = bus.res_target;
          wr_e.uncond = bus.res_uncond;
          wr_e.ctr    = bus.res_uncond ? CTR_MAX : CTR_WEAK_T;
        end
      end else if (res_hit) begin
        we       = 1'b1;
        wr_e.ctr = ctr_dec(res_e.ctr);
      end
    end
  end

`ifdef NPC_BP_STATS_EN
  logic [31:0] resolved_q;
  logic [31:0] mispred_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      resolved_q <= '0;
      mispred_q  <= '0;
    end else begin
      if (bus.res_valid) resolved_q <= resolved_q + 32'd1;
      if (mis)           mispred_q  <= mispred_q + 32'd1;
    end
  end

  assign bus.stat_resolved = resolved_q;
  assign bus.stat_mispred  = mispred_q;
`endif

endmodule

// File: doc/npc_bp.md
Name: npc_bp

Overview:
- Next-generation next-PC unit: owns the fetch PC register, predicts the next fetch address each cycle from a direct-mapped branch target buffer (BTB) with saturating counters, and repairs mispredictions reported by the execute-stage branch/jump resolver.
- Sits between IF and the resolve stage; replaces purely combinational next-PC selection with predicted fetch plus a registered redirect.
- Emits the pipeline flush on mispredict only, not on every taken branch.

Parameters:
- ADDR_W, 32, PC/target width.
- BTB_DEPTH, 16, BTB entries (power of 2, ≥2); IDX_W = log2(BTB_DEPTH).
- CTR_W, 2, saturating-counter width (≥1).
- RESET_PC, 32'h0000_3000, PC value after reset.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- stall  in  1  hold PC (load-use hazard); does not block updates or redirects.
- pc  out  ADDR_W  current fetch PC.
- pred_taken  out  1  prediction for the instruction at pc; piped along with it.
- pred_target  out  ADDR_W  predicted target for pc; valid when pred_taken=1.
- res_valid  in  1  a control-transfer instruction resolves this cycle.
- res_pc  in  ADDR_W  PC of the resolving instruction.
- res_uncond  in  1  resolving instruction is j/jal/jr/jalr.
- res_taken  in  1  actual direction.
- res_target  in  ADDR_W  actual target, already final (jr base offset applied upstream).
- res_pred_taken  in  1  prediction that travelled with the instruction.
- res_pred_target  in  ADDR_W  predicted target that travelled with it.
- flush  out  1  kill younger instructions in IF/ID this cycle.

Behaviour:
- Reset (sync, active-high): pc=RESET_PC; all BTB valid bits=0; flush=0; pred_taken=0; pred_target=0. Reset mid-redirect wins over everything.
- Lookup (combinational on pc):
  - idx = pc[IDX_W+1:2]; tag = pc[ADDR_W-1:IDX_W+2]; hit = valid[idx] & tag match.
  - pred_taken = hit & (uncond[idx] | ctr[idx] MSB).
  - pred_target = hit ? tgt[idx] : 0.
- Mispredict (combinational): mis = res_valid & ((res_taken != res_pred_taken) | (res_taken & res_target != res_pred_target)).
- flush = mis, same cycle as res_valid; not gated by stall.
- PC next-state, priority order:
  - rst → RESET_PC.
  - mis → res_taken ? res_target : res_pc+4.
  - stall → hold.
  - pred_taken → pred_target.
  - else → pc+4.
- All PC adds are modulo 2^ADDR_W; pc=FFFF_FFFC+4 wraps to 0.
- BTB update on res_valid, registered at the clock edge; visible to lookup the next cycle. A same-cycle lookup of the same index sees old contents.
  - res_taken & miss at res_pc: allocate/overwrite entry (valid=1, new tag, tgt=res_target, uncond=res_uncond, ctr = uncond ? all-ones : 10..0, i.e. weakly taken).
  - res_taken & hit: tgt=res_target; ctr saturating +1 (stays at all-ones).
  - !res_taken & hit: ctr saturating −1 (stays at 0); entry stays valid.
  - !res_taken & miss: no change (never allocate not-taken).
- Conflict aliasing: a new tag simply evicts the old entry.
- Updates proceed while stall=1.
- Upstream contract: at most one resolve per cycle; res_* are don't-care when res_valid=0.

Optional Feature:
- Macro NPC_BP_STATS_EN.
- Defined: adds outputs stat_resolved[31:0] and stat_mispred[31:0]. Both reset to 0, increment on res_valid and on mis respectively, and wrap at 2^32.
- Undefined: ports and counters absent; all other behaviour identical.

Decomposition:
- npc_bp_pkg: ADDR_W default, RESET_PC, counter constants (CTR_MAX, CTR_WEAK_T), and the BTB entry struct (valid, tag, tgt, ctr, uncond).
- One sub-module npc_bp_btb: flop array with async read port (idx → entry) and one sync write port. Top holds the PC register, mispredict logic and counter arithmetic.

Test Plan:
- Reset: assert rst 1 cycle → pc=0000_3000, flush=0; next 3 cycles with no resolve → pc 3004, 3008, 300C.
- Cold taken branch: res_valid with res_pc=3010, res_taken=1, target=3040, pred_taken=0 → flush=1 that cycle; next pc=3040; entry allocated with ctr=10. Later fetch at 3010 → pred_taken=1, pred_target=3040.
- Counter hysteresis: same branch resolved taken twice (ctr 11), then not-taken with pred_taken=1 → flush, pc=3014, ctr=10, still predicts taken. A second not-taken → ctr=01, predicts not-taken.
- Target change: jr at 3020 predicted to 3100 but resolves to 3200 → flush, pc=3200, tgt updated to 3200.
- Stall vs redirect: stall=1 held while a mispredict resolves (target 3080) → pc=3080 next cycle; stall alone for 2 cycles → pc held.
- Alias/wrap: BTB_DEPTH=16; taken branches at 3010 and 3050 (same idx 4) → second evicts first, lookup at 3010 misses. pc=FFFF_FFFC with no hit → next pc=0000_0000.
